// File: rtl/mem_pkg.sv
// Shared types and default widths for the memory arbiter, caches and write buffer.
package mem_pkg;

    localparam int AW_DEF = 30;
    localparam int DW_DEF = 32;
    localparam int BW_DEF = DW_DEF / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_WB   = 2'd1,
        GNT_D    = 2'd2,
        GNT_I    = 2'd3
    } grant_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Combinational fixed-priority picker (wb > d > i).
// The starve flag lets a waiting icache jump the queue.
module mem_arb_prio
    import mem_pkg::*;
(
    input  logic   wb_en,
    input  logic   d_en,
    input  logic   i_en,
    input  logic   starve,
    output grant_t gnt
);

    always_comb begin
        gnt = GNT_NONE;
        if (starve && i_en) gnt = GNT_I;
        else if (wb_en)     gnt = GNT_WB;
        else if (d_en)      gnt = GNT_D;
        else if (i_en)      gnt = GNT_I;
    end

endmodule

// File: rtl/mem_arbiter.sv
// Registered arbiter sharing one memory port among write buffer, dcache and icache.
// IDLE arbitrates, BUSY holds the access until memdone, DONE is a one-cycle cool-down.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int AW           = AW_DEF,
    parameter int DW           = DW_DEF,
    parameter int BW           = BW_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wb_en,
    input  logic [AW-1:0] wb_adr,
    input  logic [DW-1:0] wb_wdata,
    input  logic [BW-1:0] wb_byteen,
    output logic          wb_done,
    input  logic          d_en,
    input  logic [AW-1:0] d_adr,
    output logic [DW-1:0] d_rdata,
    output logic          d_done,
    input  logic          i_en,
    input  logic [AW-1:0] i_adr,
    output logic [DW-1:0] i_rdata,
    output logic          i_done,
    output logic [AW-1:0] memadr,
    output logic [DW-1:0] memwdata,
    output logic [BW-1:0] membyteen,
    output logic          memrwb,
    output logic          memen,
    input  logic [DW-1:0] memrdata,
    input  logic          memdone
);

    localparam int SCW = $clog2(STARVE_LIMIT + 1);

    state_t          r_state;
    grant_t          r_grant;
    logic [SCW-1:0]  r_starve_cnt;
    logic [AW-1:0]   r_memadr;
    logic [DW-1:0]   r_memwdata;
    logic [BW-1:0]   r_membyteen;
    logic            r_memrwb;
    logic            r_memen;
    logic            r_wb_done;
    logic            r_d_done;
    logic            r_i_done;
    logic [DW-1:0]   r_d_rdata;
    logic [DW-1:0]   r_i_rdata;

    grant_t          w_gnt;
    logic            w_starve;

    assign w_starve = (r_starve_cnt == SCW'(STARVE_LIMIT));

    mem_arb_prio u_prio (
        .wb_en  (wb_en),
        .d_en   (d_en),
        .i_en   (i_en),
        .starve (w_starve),
        .gnt    (w_gnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_grant      <= GNT_NONE;
            r_starve_cnt <= '0;
            r_memadr     <= '0;
            r_memwdata   <= '0;
            r_membyteen  <= '0;
            r_memrwb     <= 1'b1;
            r_memen      <= 1'b0;
            r_wb_done    <= 1'b0;
            r_d_done     <= 1'b0;
            r_i_done     <= 1'b0;
            r_d_rdata    <= '0;
            r_i_rdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_gnt != GNT_NONE) begin
                        r_grant <= w_gnt;
                        r_memen <= 1'b1;
                        r_state <= BUSY;
                        case (w_gnt)
                            GNT_WB: begin
                                r_memadr    <= wb_adr;
                                r_memwdata  <= wb_wdata;
                                r_membyteen <= wb_byteen;
                                r_memrwb    <= 1'b0;
                            end
                            GNT_D: begin
                                r_memadr    <= d_adr;
                                r_memwdata  <= '0;
                                r_membyteen <= {BW{1'b1}};
                                r_memrwb    <= 1'b1;
                            end
                            default: begin
                                r_memadr    <= i_adr;
                                r_memwdata  <= '0;
                                r_membyteen <= {BW{1'b1}};
                                r_memrwb    <= 1'b1;
                            end
                        endcase
                        // Count only grants that bypass a waiting icache
                        if (!i_en || w_gnt == GNT_I)
                            r_starve_cnt <= '0;
                        else if (!w_starve)
                            r_starve_cnt <= r_starve_cnt + SCW'(1);
                    end else begin
                        r_starve_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (memdone) begin
                        r_memen <= 1'b0;
                        r_state <= DONE;
                        case (r_grant)
                            GNT_WB: r_wb_done <= 1'b1;
                            GNT_D: begin
                                r_d_done  <= 1'b1;
                                r_d_rdata <= memrdata;
                            end
                            GNT_I: begin
                                r_i_done  <= 1'b1;
                                r_i_rdata <= memrdata;
                            end
                            default: ;
                        endcase
                    end
                end
                DONE: begin
                    r_wb_done <= 1'b0;
                    r_d_done  <= 1'b0;
                    r_i_done  <= 1'b0;
                    r_grant   <= GNT_NONE;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign memadr    = r_memadr;
    assign memwdata  = r_memwdata;
    assign membyteen = r_membyteen;
    assign memrwb    = r_memrwb;
    assign memen     = r_memen;
    assign wb_done   = r_wb_done;
    assign d_done    = r_d_done;
    assign i_done    = r_i_done;
    assign d_rdata   = r_d_rdata;
    assign i_rdata   = r_i_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: expected memory transactions are queued when
// requests are raised and popped as the arbiter issues them.
module tb_mem_arbiter;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_en, d_en, i_en;
    logic [29:0] wb_adr, d_adr, i_adr;
    logic [31:0] wb_wdata;
    logic [3:0]  wb_byteen;
    logic        wb_done, d_done, i_done;
    logic [31:0] d_rdata, i_rdata;
    logic [29:0] memadr;
    logic [31:0] memwdata, memrdata;
    logic [3:0]  membyteen;
    logic        memrwb, memen, memdone;

    typedef struct {
        int          who;   // 0 wb, 1 d, 2 i
        logic [29:0] adr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        rwb;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_d = '0;
    logic [31:0] exp_i = '0;

    mem_arbiter #(.AW(30), .DW(32), .BW(4), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .wb_en(wb_en), .wb_adr(wb_adr), .wb_wdata(wb_wdata), .wb_byteen(wb_byteen), .wb_done(wb_done),
        .d_en(d_en), .d_adr(d_adr), .d_rdata(d_rdata), .d_done(d_done),
        .i_en(i_en), .i_adr(i_adr), .i_rdata(i_rdata), .i_done(i_done),
        .memadr(memadr), .memwdata(memwdata), .membyteen(membyteen), .memrwb(memrwb),
        .memen(memen), .memrdata(memrdata), .memdone(memdone)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input int who);
        exp_t e;
        e.who = who;
        case (who)
            0: begin e.adr = wb_adr; e.wdata = wb_wdata; e.be = wb_byteen; e.rwb = 1'b0; end
            1: begin e.adr = d_adr;  e.wdata = '0;       e.be = 4'hF;      e.rwb = 1'b1; end
            default: begin e.adr = i_adr; e.wdata = '0;  e.be = 4'hF;      e.rwb = 1'b1; end
        endcase
        q.push_back(e);
    endtask

    // Wait for the next grant, check it against the queue head, ack after lat cycles.
    task automatic serve(input int lat, input logic [31:0] rd, input bit chk_gap, input bit drop);
        int   n;
        exp_t e;
        n = 0;
        while (memen !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("grant_timeout", 64'(n < 50), 64'(1));
        if (chk_gap) chk("grant_gap", 64'(n), 64'(1));
        if (q.size() == 0) begin
            errors++;
            $error("FAIL sb_empty observed=grant expected=none");
            return;
        end
        e = q.pop_front();
        chk("memadr", 64'(memadr), 64'(e.adr));
        chk("memwdata", 64'(memwdata), 64'(e.wdata));
        chk("membyteen", 64'(membyteen), 64'(e.be));
        chk("memrwb", 64'(memrwb), 64'(e.rwb));
        if (drop) begin
            wb_en = 0; d_en = 0; i_en = 0;
            wb_adr = ~wb_adr; d_adr = ~d_adr; i_adr = ~i_adr;
        end
        for (int k = 1; k < lat; k++) begin
            @(negedge clk);
            chk("busy_memen", 64'(memen), 64'(1));
            chk("busy_adr", 64'(memadr), 64'(e.adr));
        end
        memrdata = rd;
        memdone  = 1'b1;
        @(negedge clk);
        memdone  = 1'b0;
        memrdata = 32'h0;
        chk("done_memen", 64'(memen), 64'(0));
        chk("done_pulse", 64'({wb_done, d_done, i_done}),
            64'({e.who == 0, e.who == 1, e.who == 2}));
        if (e.who == 1) exp_d = rd;
        if (e.who == 2) exp_i = rd;
        chk("d_rdata", 64'(d_rdata), 64'(exp_d));
        chk("i_rdata", 64'(i_rdata), 64'(exp_i));
        @(negedge clk);
        chk("done_clear", 64'({wb_done, d_done, i_done}), 64'(0));
        chk("idle_memen", 64'(memen), 64'(0));
    endtask

    initial begin
        reset = 1'b0;
        wb_en = 0; d_en = 0; i_en = 0;
        wb_adr = '0; d_adr = '0; i_adr = '0;
        wb_wdata = '0; wb_byteen = '0;
        memrdata = '0; memdone = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_memen", 64'(memen), 64'(0));
        chk("rst_memrwb", 64'(memrwb), 64'(1));
        chk("rst_memadr", 64'({memadr, membyteen}), 64'(0));
        chk("rst_done", 64'({wb_done, d_done, i_done}), 64'(0));
        chk("rst_rdata", 64'({d_rdata, i_rdata}), 64'(0));
        reset = 1'b1;
        @(negedge clk);

        // single write, ack after 2 cycles
        wb_adr = 30'h10; wb_wdata = 32'hDEADBEEF; wb_byteen = 4'b1101; wb_en = 1;
        push(0);
        serve(2, 32'h0, 1, 0);
        wb_en = 0;

        // single dcache read; requester drops en and changes address while busy
        d_adr = 30'h0; d_en = 1;
        push(1);
        serve(1, 32'hAAAAAAAA, 1, 1);

        // icache read, slow ack; d_rdata must hold
        i_adr = 30'h123; i_en = 1;
        push(2);
        serve(3, 32'h55551234, 1, 0);
        i_en = 0;

        // all three at once: wb, d, i with 2-cycle gaps
        wb_adr = 30'h20; wb_wdata = 32'hCAFEF00D; wb_byteen = 4'b0011;
        d_adr = 30'h44; i_adr = 30'h88;
        wb_en = 1; d_en = 1; i_en = 1;
        push(0); push(1); push(2);
        serve(1, 32'h0, 1, 0);
        wb_en = 0;
        serve(2, 32'h11111111, 1, 0);
        d_en = 0;
        serve(1, 32'h22222222, 1, 0);
        i_en = 0;

        // starvation: four wb grants, then the override hands the port to i
        wb_adr = 30'h30; wb_wdata = 32'h12345678; wb_byteen = 4'hF;
        d_adr = 30'h55; i_adr = 30'h4AD;
        wb_en = 1; d_en = 1; i_en = 1;
        push(0); push(0); push(0); push(0); push(2);
        for (int g = 0; g < 4; g++) serve(1, 32'h0, 1, 0);
        chk("starve_sat", 64'(dut.r_starve_cnt), 64'(4));
        serve(1, 32'h0BAD04AD, 1, 0);
        wb_en = 0; d_en = 0; i_en = 0;
        chk("starve_clr", 64'(dut.r_starve_cnt), 64'(0));

        // reset in the middle of a busy access
        d_adr = 30'h77; d_en = 1;
        @(negedge clk);
        chk("pre_rst_memen", 64'(memen), 64'(1));
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_memen", 64'(memen), 64'(0));
        chk("mid_rst_mem", 64'({memadr, memwdata, membyteen}), 64'(0));
        chk("mid_rst_rwb", 64'(memrwb), 64'(1));
        chk("mid_rst_out", 64'({wb_done, d_done, i_done, d_rdata, i_rdata}), 64'(0));
        exp_d = '0; exp_i = '0;
        d_en = 0;
        @(negedge clk);
        reset = 1'b1;
        memdone = 1'b1;
        @(negedge clk);
        memdone = 1'b0;
        chk("late_ack_done", 64'({wb_done, d_done, i_done}), 64'(0));
        chk("late_ack_memen", 64'(memen), 64'(0));

        // spurious memdone while idle
        memdone = 1'b1;
        @(negedge clk);
        memdone = 1'b0;
        @(negedge clk);
        chk("spur_done", 64'({wb_done, d_done, i_done}), 64'(0));
        chk("spur_memen", 64'(memen), 64'(0));
        chk("spur_state", 64'(dut.r_state), 64'(IDLE));

        // normal operation resumes after reset
        d_adr = 30'h9; d_en = 1;
        push(1);
        serve(2, 32'h0BADCAFE, 1, 0);
        d_en = 0;

        if (q.size() != 0) begin
            errors++;
            $error("FAIL sb_leftover observed=%0d expected=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
